mem_stream_reader: RTL and testbench
====================================

// Module: mem_stream_reader
// PURPOSE
//  Read-side initiator for one port of the dual-port generic_memory.
//  On start, reads `length` consecutive words from base_addr and emits them as a
//  valid/ready stream with out_last on the final word. Absorbs the memory's
//  1-cycle registered read latency and downstream backpressure.
//  Feeds layer weights/pixels from on-chip RAM into the digit-recognition datapath.
// PARAMETERS
//  WORD_SIZE   16  data width; must match the attached memory
//  ADDR_WIDTH  6   address width; memory depth = 2**ADDR_WIDTH
// PORTS
//  clk        in   1             single clock; all logic on posedge
//  reset      in   1             synchronous, active-high
//  start      in   1             begin a transfer; sampled only while idle
//  base_addr  in   ADDR_WIDTH    first word address; captured with start
//  length     in   ADDR_WIDTH+1  word count, 0..2**ADDR_WIDTH; captured with start
//  busy       out  1             transfer in progress
//  done       out  1             1-cycle pulse at end of transfer
//  mem_addr   out  ADDR_WIDTH    to memory addr port
//  mem_we     out  1             to memory we port; constant 0
//  mem_q      in   WORD_SIZE     from memory q port
//  out_data   out  WORD_SIZE     stream data
//  out_valid  out  1             stream valid
//  out_ready  in   1             stream ready from consumer
//  out_last   out  1             qualifies the final word of the transfer
// BEHAVIOUR
//  Memory timing:
//   - mem_addr presented in cycle N -> mem_q = ram[addr] during cycle N+1.
//   - Captured into the internal FIFO at the end of N+1.
//  Reset (sync, dominates everything):
//   - Outputs: busy=0, done=0, out_valid=0, out_last=0, mem_addr=0, out_data=0.
//   - FIFO flushed, in-flight read discarded, FSM to IDLE.
//   - Mid-transfer reset abandons the transfer with no done pulse.
//  FSM IDLE -> RUN -> IDLE:
//   - IDLE: start=1 and length!=0 -> capture base_addr/length, go RUN.
//     start=1 and length==0 -> done=1 next cycle, stay IDLE, no reads.
//   - RUN: busy=1. start ignored (no queueing).
//     Leave to IDLE in the cycle after the handshake with out_last=1.
//     done=1 for exactly that one cycle; busy=0 in the same cycle.
//  Read issue, one per cycle:
//   - Condition: RUN, issued<length, fifo_count+inflight<3.
//   - Independent of out_ready this cycle; no combinational path ready->mem_addr.
//   - Address = base_addr+issued, mod 2**ADDR_WIDTH (wraps past top to 0).
//  FIFO:
//   - 3 entries of {data,last}; last set on the word with index length-1.
//   - The 3-credit rule guarantees no overflow.
//   - out_valid = FIFO non-empty; pop on out_valid&out_ready.
//   - out_data/out_last stable while out_valid=1 and out_ready=0.
//  Latency and throughput:
//   - start in cycle T -> first read issued T+1 -> out_valid with ram[base] in T+3.
//   - With out_ready held high, sustains 1 word/cycle.
//  Boundaries:
//   - length=2**ADDR_WIDTH reads every word exactly once.
//   - Simultaneous push and pop keep the count unchanged.
//   - out_ready low for any duration: issue stalls at 3 credits, no word lost or duplicated.
// TESTING
//  1. RAM[i]=i+100; start base=4 len=5, ready=1.
//     -> data 104..108 on consecutive cycles T+3..T+7; last only on 108; done at T+8.
//  2. base=62 len=4, ADDR_WIDTH=6.
//     -> addresses 62,63,0,1; data ram[62],ram[63],ram[0],ram[1].
//  3. len=6, out_ready toggles 1,0,0,1 repeating.
//     -> exactly 6 in-order beats; FIFO never exceeds 3; data held stable while stalled.
//  4. start with len=0 -> done pulse at T+1; busy, out_valid, mem_addr activity all stay 0.
//  5. reset asserted mid-transfer after 2 beats.
//     -> next cycle out_valid=0, busy=0, no done; new start base=0 len=1 returns ram[0] at T+3.
//  6. start pulsed again while busy, with different base -> ignored; original stream unaffected.

Source files
------------

// File: rtl/mem_stream_reader.sv
// Streams `length` consecutive memory words from base_addr as a valid/ready
// stream, absorbing the 1-cycle read latency through a 3-entry credit FIFO.
module mem_stream_reader #(
    parameter int WORD_SIZE  = 16,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    input  logic [WORD_SIZE-1:0]  mem_q,
    output logic [WORD_SIZE-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam int LW = ADDR_WIDTH + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_nx;

    logic [ADDR_WIDTH-1:0] base_r;
    logic [LW-1:0]         len_r;
    logic [LW-1:0]         issued;
    logic                  inflight;
    logic                  inflight_last;
    logic                  done_r;

    logic [WORD_SIZE-1:0]  fifo_data [3];
    logic                  fifo_last [3];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [1:0]            count;

    logic start_run;
    logic start_zero;
    logic push;
    logic pop;
    logic final_pop;
    logic issue_en;
    logic issue_last;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign start_run  = (state == IDLE) && start && (length != '0);
    assign start_zero = (state == IDLE) && start && (length == '0);
    assign push       = inflight;
    assign pop        = out_valid && out_ready;
    assign final_pop  = pop && out_last;
    assign issue_last = (issued == len_r - LW'(1));

    // Credits count both stored words and the read still in the memory,
    // so a stalled consumer can never overflow the FIFO.
    assign issue_en = (state == RUN) && (issued < len_r) &&
                      (({1'b0, count} + {2'b00, inflight}) < 3'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start_run) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (final_pop) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == RUN);
        done      = done_r;
        mem_we    = 1'b0;
        mem_addr  = '0;
        out_valid = (count != 2'd0);
        out_data  = '0;
        out_last  = 1'b0;
        if (issue_en) begin
            mem_addr = base_r + issued[ADDR_WIDTH-1:0];
        end
        if (out_valid) begin
            out_data = fifo_data[rd_ptr];
            out_last = fifo_last[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_r        <= '0;
            len_r         <= '0;
            issued        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            if (start_run) begin
                base_r <= base_addr;
                len_r  <= length;
                issued <= '0;
            end else if (issue_en) begin
                issued <= issued + LW'(1);
            end
            inflight      <= issue_en;
            inflight_last <= issue_en && issue_last;
            done_r        <= start_zero || ((state == RUN) && final_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= mem_q;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Bench for mem_stream_reader: behavioural RAM plus an expected-stream model
// derived from base/length, with directed and randomized transfers.
module tb_mem_stream_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  base_addr;
    logic [6:0]  length;
    logic        busy;
    logic        done;
    logic [5:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_q;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    logic [15:0] ram [64];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    mem_stream_reader #(.WORD_SIZE(16), .ADDR_WIDTH(6)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .base_addr(base_addr),
        .length(length),
        .busy(busy),
        .done(done),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .mem_q(mem_q),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        mem_q <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ((k % 4) == 0) || ((k % 4) == 3);
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic xfer(input logic [5:0] b, input logic [6:0] l,
                        input int mode, input bit inject);
        int          t;
        int          idx;
        int          n;
        bit          fin;
        logic        stall;
        logic [15:0] pd;
        logic        pl;
        logic [5:0]  ea;
        @(negedge clk);
        start     = 1'b1;
        base_addr = b;
        length    = l;
        out_ready = 1'b1;
        t         = cyc;
        @(negedge clk);
        idx   = 0;
        n     = 0;
        fin   = 1'b0;
        stall = 1'b0;
        pd    = '0;
        pl    = 1'b0;
        while (!fin && n < 400) begin
            out_ready = rdy(mode, n);
            if (inject && n == 3) begin
                start     = 1'b1;
                base_addr = b + 6'd20;
                length    = 7'd3;
            end else begin
                start     = 1'b0;
                base_addr = 6'($urandom);
                length    = 7'($urandom);
            end
            #1;
            chk("mem_we", mem_we, 0);
            if (mode == 0 && n < int'(l)) begin
                ea = 6'(b + n);
                chk("issue_addr", mem_addr, ea);
            end
            if (out_valid) begin
                if (stall) begin
                    chk("hold_data", out_data, pd);
                    chk("hold_last", out_last, pl);
                end
                if (out_ready) begin
                    if (idx >= int'(l)) begin
                        chk("extra_beat", 1, 0);
                    end else begin
                        ea = 6'(b + idx);
                        chk("beat_data", out_data, ram[ea]);
                        chk("beat_last", out_last, (idx == int'(l) - 1));
                        if (mode == 0) chk("beat_cycle", cyc, t + 3 + idx);
                    end
                    idx++;
                    stall = 1'b0;
                end else begin
                    stall = 1'b1;
                    pd    = out_data;
                    pl    = out_last;
                end
            end else if (stall) begin
                chk("lost_word", 0, 1);
                stall = 1'b0;
            end
            if (done) begin
                chk("done_count", idx, l);
                chk("done_busy", busy, 0);
                if (mode == 0) chk("done_cycle", cyc, t + 3 + int'(l));
                fin = 1'b1;
            end else begin
                chk("busy_run", busy, 1);
            end
            @(negedge clk);
            n++;
        end
        if (!fin) chk("timeout", 0, 1);
        start = 1'b0;
        #1;
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_valid", out_valid, 0);
    endtask

    initial begin
        int beats;
        int t;
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 64; i++) ram[i] = 16'(i + 100);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", out_data, 0);
        @(negedge clk);
        reset = 1'b0;

        xfer(6'd4, 7'd5, 0, 1'b0);
        xfer(6'd62, 7'd4, 0, 1'b0);
        xfer(6'd9, 7'd6, 1, 1'b0);

        @(negedge clk);
        start     = 1'b1;
        base_addr = 6'd7;
        length    = 7'd0;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_valid", out_valid, 0);
        chk("zero_addr", mem_addr, 0);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("zero_after_done", done, 0);
            chk("zero_after_busy", busy, 0);
            chk("zero_after_addr", mem_addr, 0);
        end

        @(negedge clk);
        start     = 1'b1;
        base_addr = 6'd10;
        length    = 7'd8;
        out_ready = 1'b1;
        t         = cyc;
        beats     = 0;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t + 5) begin
            #1;
            if (out_valid && out_ready) beats++;
            @(negedge clk);
        end
        chk("pre_reset_beats", beats, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_done", done, 0);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("post_rst_no_done", done, 0);
            chk("post_rst_no_valid", out_valid, 0);
        end
        xfer(6'd0, 7'd1, 0, 1'b0);

        xfer(6'd20, 7'd6, 1, 1'b1);
        xfer(6'd0, 7'd64, 0, 1'b0);

        for (int i = 0; i < 64; i++) ram[i] = 16'($urandom);
        xfer(6'd33, 7'd64, 2, 1'b0);
        repeat (10) begin
            xfer(6'($urandom), 7'($urandom_range(1, 64)),
                 int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
